// File: rtl/gf180mcu_fd_sc_mcu9t5v0__orn_pipe.sv
// Purpose: pipelined WIDTH-input OR reduction (4-input OR tree) with valid strobe and sticky flag.
// Latency: LEVELS cycles from an EN=1 sample to Z/ZV/ZS, LEVELS = max(1, ceil(log4(WIDTH))).
// Backpressure: none; accepts one sample per cycle, EN=0 bubbles travel through as ZV=0.
module gf180mcu_fd_sc_mcu9t5v0__orn_pipe #(
    parameter int WIDTH = 16
) (
`ifdef USE_POWER_PINS
    inout  wire              VDD,
    inout  wire              VSS,
`endif
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [WIDTH-1:0] A,
    input  logic             CLR,
    output logic             Z,
    output logic             ZV,
    output logic             ZS
);

    // Number of nodes left after reducing w inputs by l levels of 4-input ORs.
    function automatic int width_at(input int w, input int l);
        int n;
        n = w;
        for (int i = 0; i < l; i++) begin
            n = (n + 3) / 4;
        end
        return n;
    endfunction

    // Tree depth; a single input still gets one register stage.
    function automatic int calc_levels(input int w);
        int n;
        int l;
        n = w;
        l = 0;
        while (n > 1) begin
            n = (n + 3) / 4;
            l++;
        end
        return (l < 1) ? 1 : l;
    endfunction

    localparam int LEVELS = calc_levels(WIDTH);

    for (genvar g = 0; g < LEVELS; g++) begin : lv
        localparam int NI = width_at(WIDTH, g);
        localparam int NO = width_at(WIDTH, g + 1);

        logic [NI-1:0]   din;
        logic            vin;
        logic [4*NO-1:0] pad;
        logic [NO-1:0]   red;
        logic [NO-1:0]   q;
        logic            v;

        if (g == 0) begin : src_in
            assign din = A;
            assign vin = EN;
        end else begin : src_prev
            assign din = lv[g-1].q;
            assign vin = lv[g-1].v;
        end

        // Zero-pad a trailing partial group, then OR each group of four.
        always_comb begin
            pad = '0;
            pad[NI-1:0] = din;
            red = '0;
            for (int o = 0; o < NO; o++) begin
                red[o] = |pad[4*o +: 4];
            end
        end

        // Valid shifts every cycle; data only loads behind a valid so it holds across bubbles.
        always_ff @(posedge CLK) begin
            if (RST) begin
                q <= '0;
                v <= 1'b0;
            end else begin
                v <= vin;
                if (vin) begin
                    q <= red;
                end
            end
        end
    end

    // Sticky flag: a valid 1-result arriving at the output stage wins over a same-edge clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ZS <= 1'b0;
        end else begin
            ZS <= (CLR ? 1'b0 : ZS) | (lv[LEVELS-1].vin & lv[LEVELS-1].red[0]);
        end
    end

    assign Z  = lv[LEVELS-1].q[0];
    assign ZV = lv[LEVELS-1].v;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__orn_pipe.sv
// Bench for the pipelined OR reduction: four widths (16, 5, 1, 64) driven from one shared input bus.
// Hand-computed vector table for WIDTH=16, directed corner sequences, then random traffic vs a delay-line model.
// Outputs are sampled on the falling edge; inputs change only there.
module tb_gf180mcu_fd_sc_mcu9t5v0__orn_pipe;

    logic        CLK;
    logic        RST;
    logic        EN;
    logic        CLR;
    logic [63:0] a_bus;
    logic [3:0]  zo;
    logic [3:0]  zvo;
    logic [3:0]  zso;

    int checks = 0;
    int fails  = 0;

    gf180mcu_fd_sc_mcu9t5v0__orn_pipe #(.WIDTH(16)) u_w16 (
        .CLK(CLK), .RST(RST), .EN(EN), .A(a_bus[15:0]), .CLR(CLR),
        .Z(zo[0]), .ZV(zvo[0]), .ZS(zso[0])
    );
    gf180mcu_fd_sc_mcu9t5v0__orn_pipe #(.WIDTH(5)) u_w5 (
        .CLK(CLK), .RST(RST), .EN(EN), .A(a_bus[4:0]), .CLR(CLR),
        .Z(zo[1]), .ZV(zvo[1]), .ZS(zso[1])
    );
    gf180mcu_fd_sc_mcu9t5v0__orn_pipe #(.WIDTH(1)) u_w1 (
        .CLK(CLK), .RST(RST), .EN(EN), .A(a_bus[0:0]), .CLR(CLR),
        .Z(zo[2]), .ZV(zvo[2]), .ZS(zso[2])
    );
    gf180mcu_fd_sc_mcu9t5v0__orn_pipe #(.WIDTH(64)) u_w64 (
        .CLK(CLK), .RST(RST), .EN(EN), .A(a_bus), .CLR(CLR),
        .Z(zo[3]), .ZV(zvo[3]), .ZS(zso[3])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: each width is a plain delay line of (valid, OR-of-sample) pairs.
    int   wid[4] = '{16, 5, 1, 64};
    int   lat[4] = '{2, 2, 1, 3};
    logic hv[4][3];
    logic hd[4][3];
    logic ez[4];
    logic ezv[4];
    logic ezs[4];

    function automatic logic [63:0] mask_of(input int w);
        logic [63:0] m;
        m = '0;
        for (int b = 0; b < w; b++) m[b] = 1'b1;
        return m;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 3; k++) begin
                hv[i][k] = 1'b0;
                hd[i][k] = 1'b0;
            end
            ez[i]  = 1'b0;
            ezv[i] = 1'b0;
            ezs[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic c, input logic [63:0] av);
        if (r) begin
            model_clear();
        end else begin
            for (int i = 0; i < 4; i++) begin
                for (int k = lat[i] - 1; k > 0; k--) begin
                    hv[i][k] = hv[i][k-1];
                    hd[i][k] = hd[i][k-1];
                end
                hv[i][0] = e;
                hd[i][0] = |(av & mask_of(wid[i]));
                ezv[i] = hv[i][lat[i]-1];
                if (ezv[i]) ez[i] = hd[i][lat[i]-1];
                ezs[i] = (c ? 1'b0 : ezs[i]) | (ezv[i] & hd[i][lat[i]-1]);
            end
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b, required %0b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("model_w%0d_z", wid[i]),  zo[i],  ez[i]);
            chk($sformatf("model_w%0d_zv", wid[i]), zvo[i], ezv[i]);
            chk($sformatf("model_w%0d_zs", wid[i]), zso[i], ezs[i]);
        end
    endtask

    // One clock: drive inputs, take the edge, update the model, compare on the falling edge.
    task automatic step(input logic r, input logic e, input logic c, input logic [63:0] av);
        RST   = r;
        EN    = e;
        CLR   = c;
        a_bus = av;
        @(posedge CLK);
        model_edge(r, e, c, av);
        @(negedge CLK);
        check_all();
    endtask

    typedef struct {
        logic        rst;
        logic        en;
        logic        clr;
        logic [63:0] a;
        logic        z;
        logic        zv;
        logic        zs;
    } vec_t;

    vec_t tbl[14];

    initial begin
        logic [63:0] ra;
        int          sel;

        RST = 1'b1; EN = 1'b0; CLR = 1'b0; a_bus = '0;
        model_clear();

        // Expected WIDTH=16 outputs after each edge, worked out by hand.
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 64'h0100,                1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 64'h0,                   1'b1, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 64'h0,                   1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 64'h0,                   1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 64'h0,                   1'b0, 1'b1, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 64'h0,                   1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 64'h0001,                1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 64'h0,                   1'b1, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 64'h8000,                1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 64'h0,                   1'b1, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 64'h0,                   1'b0, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 64'h0,                   1'b0, 1'b0, 1'b0};

        @(negedge CLK);
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].a);
            chk($sformatf("tbl%0d_z", i),  zo[0],  tbl[i].z);
            chk($sformatf("tbl%0d_zv", i), zvo[0], tbl[i].zv);
            chk($sformatf("tbl%0d_zs", i), zso[0], tbl[i].zs);
        end

        // Padding: bit 4 of a 5-wide input sits alone in a padded group.
        step(1'b0, 1'b0, 1'b1, 64'h0);
        step(1'b0, 1'b1, 1'b0, 64'h10);
        chk("pad1_z_bit4", zo[2], 1'b0);
        chk("pad1_zv", zvo[2], 1'b1);
        step(1'b0, 1'b0, 1'b0, 64'h0);
        chk("pad5_z_one", zo[1], 1'b1);
        chk("pad5_zv", zvo[1], 1'b1);
        step(1'b0, 1'b1, 1'b0, 64'h0);
        step(1'b0, 1'b0, 1'b0, 64'h0);
        chk("pad5_z_zero", zo[1], 1'b0);
        step(1'b0, 1'b1, 1'b0, 64'h1);
        chk("w1_z_follow", zo[2], 1'b1);
        chk("w1_zv_follow", zvo[2], 1'b1);

        // Reset while a sample is inside the 3-level tree.
        step(1'b0, 1'b0, 1'b1, 64'h0);
        step(1'b0, 1'b0, 1'b1, 64'h0);
        step(1'b0, 1'b0, 1'b1, 64'h0);
        step(1'b0, 1'b1, 1'b0, 64'h1);
        step(1'b1, 1'b0, 1'b0, 64'h0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b0, 64'h0);
            chk($sformatf("midflight_zv%0d", k), zvo[3], 1'b0);
        end
        chk("midflight_z", zo[3], 1'b0);
        chk("midflight_zs", zso[3], 1'b0);

        // Random traffic with sparse flags so results are a mix of 0 and 1.
        for (int n = 0; n < 400; n++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       ra = 64'h0;
                1:       ra = 64'h1 << $urandom_range(0, 7);
                2:       ra = 64'h1 << $urandom_range(0, 63);
                default: ra = {$urandom, $urandom};
            endcase
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 7) == 0), ra);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
